hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Stall/flush controller for the 5-stage MIPS pipeline, paired with the EX-stage forwarding unit. It covers the hazards forwarding cannot resolve:
- load-use,
- ID-resolved branches waiting on in-flight results,
- data-memory wait states.
It drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush, and keeps saturating stall statistics plus a sticky memory-timeout error.

Parameters:
CNT_W, 16, width of each saturating performance counter
TIMEOUT, 64, consecutive not-ready memory cycles before mem_timeout sets (must be >= 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
IFID_rs  in  5  rs of instruction in ID
IFID_rt  in  5  rt of instruction in ID
IFID_usesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
ID_branch  in  1  ID instruction is beq/bne (compared in ID)
ID_branchTaken  in  1  ID comparator result, valid when ID_branch
IDEX_memRead  in  1  EX instruction is a load
IDEX_regWrite  in  1  EX instruction writes a register
IDEX_desReg  in  5  EX destination register
EXMEM_memRead  in  1  MEM instruction is a load
EXMEM_memWrite  in  1  MEM instruction is a store
EXMEM_desReg  in  5  MEM destination register
dmem_ready  in  1  data memory completes access this cycle
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register enable
IDEX_bubble  out  1  zero ID/EX control fields
IFID_flush  out  1  clear IF/ID to nop
pipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB
stall_cycles  out  CNT_W  count of hazard-stall cycles
flush_count  out  CNT_W  count of taken-branch flushes
memwait_cycles  out  CNT_W  count of freeze cycles
mem_timeout  out  1  sticky memory-timeout error

Behaviour:
- Register 0 never causes a hazard. All matches are qualified by a non-zero destination register.
- rsHit(x) = (x == IFID_rs). rtHit(x) = IFID_usesRt && (x == IFID_rt).
- load_use = IDEX_memRead && (rsHit || rtHit)(IDEX_desReg).
- br_hz = ID_branch && one of the following:
  - IDEX_regWrite && hit(IDEX_desReg)
  - EXMEM_memRead && hit(EXMEM_desReg)
- A load feeding a branch therefore stalls 2 cycles: load in EX, then load in MEM.
- mem_busy = (EXMEM_memRead || EXMEM_memWrite) && !dmem_ready.
- FSM states: RUN, MEM_WAIT. Registered state; outputs are combinational from state and inputs.
- RUN:
  - if mem_busy: pipeFreeze=1, PCWrite=0, IFIDWrite=0, no bubble, no flush. Next state MEM_WAIT.
  - else if load_use || br_hz: PCWrite=0, IFIDWrite=0, IDEX_bubble=1.
  - else if ID_branch && ID_branchTaken: IFID_flush=1, PCWrite=1.
  - else all enables 1, bubble, flush and freeze 0.
- MEM_WAIT:
  - Outputs are the freeze outputs while !dmem_ready.
  - On dmem_ready: outputs are as RUN without mem_busy, i.e. the held hazard or flush resolves in the same cycle. Next state RUN.
- Priority: freeze > hazard stall > flush. A flush is never issued while stalling, because the branch operands are not yet valid.
- Wait counter: counts consecutive freeze cycles and clears in RUN. When it reaches TIMEOUT, mem_timeout=1 and stays set until reset. The pipeline stays frozen.
- Counters:
  - stall_cycles increments on each hazard-stall cycle.
  - flush_count increments on each IFID_flush cycle.
  - memwait_cycles increments on each freeze cycle.
  - All saturate at all-ones.
- Reset, effective at the next edge, including mid-MEM_WAIT:
  - state=RUN; counters, wait counter and mem_timeout are 0.
  - Outputs then follow RUN rules with current inputs.
- While reset is high, outputs are forced to: PCWrite=1, IFIDWrite=1, IDEX_bubble=0, IFID_flush=0, pipeFreeze=0.

Decomposition:
- Shared package mips_pkg: state encoding (ST_RUN, ST_MEM_WAIT), REG_ZERO=5'd0, opcode constants for beq/bne/lw/sw used by the decode that produces usesRt/ID_branch.
- One sub-module: sat_counter (CNT_W, inc, reset), instantiated three times.

Test Plan:
- lw $2 in EX, ID add $3,$2,$4 (IDEX_memRead=1, IDEX_desReg=2, IFID_rs=2) -> one cycle PCWrite=0, IFIDWrite=0, IDEX_bubble=1; stall_cycles=1; next cycle no stall.
- lw $5 then beq $5,$6 in ID -> stall 2 consecutive cycles (EX match, then EXMEM match); then taken -> IFID_flush=1 for one cycle; stall_cycles=2, flush_count=1.
- lw $0 in EX with IFID_rs=0 -> no stall; add $7 in EX, beq $7 in ID -> exactly one stall cycle.
- sw in MEM with dmem_ready=0 for 3 cycles, concurrent load_use -> pipeFreeze=1 and no bubble for 3 cycles. Ready cycle gives bubble=1. memwait_cycles=3, state back to RUN.
- dmem_ready held 0 with TIMEOUT=4 -> mem_timeout=1 after 4th freeze cycle and stays 1 after ready. Reset -> mem_timeout=0, all counters 0.
- Reset asserted mid-MEM_WAIT with hazards active -> during reset PCWrite=1, IFIDWrite=1, others 0; after reset, RUN-rule outputs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: hazard-controller state encoding, the
// hard-wired zero register and the opcodes the ID decoder uses to derive
// usesRt / branch for the hazard logic.
package mips_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // A producer register matches a consumer source only when the source is
    // actually read and the producer is not $zero (writes to $zero vanish).
    function automatic logic reg_match(input logic [4:0] des,
                                       input logic [4:0] src,
                                       input logic       src_used);
        return src_used && (des != REG_ZERO) && (des == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, hold once all-ones so statistics never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline. Resolves load-use and
// ID-branch operand hazards with a bubble, flushes IF/ID on taken branches and
// freezes the back end while data memory is not ready. Keeps saturating stall
// statistics and a sticky memory-timeout flag.
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_usesRt,
    input  logic             ID_branch,
    input  logic             ID_branchTaken,
    input  logic             IDEX_memRead,
    input  logic             IDEX_regWrite,
    input  logic [4:0]       IDEX_desReg,
    input  logic             EXMEM_memRead,
    input  logic             EXMEM_memWrite,
    input  logic [4:0]       EXMEM_desReg,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             pipeFreeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_hz;
    logic mem_busy;
    logic freeze;
    logic hazard_stall;
    logic do_flush;

    // Operand matches against the EX and MEM producers (never on $zero).
    assign ex_hit  = reg_match(IDEX_desReg, IFID_rs, 1'b1) ||
                     reg_match(IDEX_desReg, IFID_rt, IFID_usesRt);
    assign mem_hit = reg_match(EXMEM_desReg, IFID_rs, 1'b1) ||
                     reg_match(EXMEM_desReg, IFID_rt, IFID_usesRt);

    assign load_use = IDEX_memRead && ex_hit;
    // Branches compare in ID, so an ALU result still in EX or a load still in
    // MEM cannot be forwarded in time; a load feeding a branch stalls twice.
    assign br_hz    = ID_branch && ((IDEX_regWrite && ex_hit) ||
                                    (EXMEM_memRead && mem_hit));
    assign mem_busy = (EXMEM_memRead || EXMEM_memWrite) && !dmem_ready;

    // Priority freeze > hazard stall > flush; the branch outcome is only
    // trusted once its operands are ready, so no flush while stalling.
    always_comb begin
        freeze       = 1'b0;
        hazard_stall = 1'b0;
        do_flush     = 1'b0;
        if (!reset) begin
            if (state == ST_MEM_WAIT) begin
                freeze = !dmem_ready;
            end else begin
                freeze = mem_busy;
            end
            if (!freeze) begin
                if (load_use || br_hz) begin
                    hazard_stall = 1'b1;
                end else if (ID_branch && ID_branchTaken) begin
                    do_flush = 1'b1;
                end
            end
        end
    end

    assign PCWrite     = !(freeze || hazard_stall);
    assign IFIDWrite   = !(freeze || hazard_stall);
    assign IDEX_bubble = hazard_stall;
    assign IFID_flush  = do_flush;
    assign pipeFreeze  = freeze;
    assign mem_timeout = timeout_q;

    // Track memory wait state and consecutive freeze cycles; timeout is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN:      state <= mem_busy   ? ST_MEM_WAIT : ST_RUN;
                ST_MEM_WAIT: state <= dmem_ready ? ST_RUN      : ST_MEM_WAIT;
                default:     state <= ST_RUN;
            endcase
            if (freeze) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_LAST) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hazard_stall),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (do_flush),
        .count (flush_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze),
        .count (memwait_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected outputs are pushed when a
// cycle's inputs are driven and popped/compared on the following negedge.
module tb_hazard_stall_unit;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] IFID_rs, IFID_rt, IDEX_desReg, EXMEM_desReg;
    logic IFID_usesRt, ID_branch, ID_branchTaken, IDEX_memRead, IDEX_regWrite;
    logic EXMEM_memRead, EXMEM_memWrite, dmem_ready;
    logic PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipeFreeze, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count, memwait_cycles;

    hazard_stall_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_usesRt    (IFID_usesRt),
        .ID_branch      (ID_branch),
        .ID_branchTaken (ID_branchTaken),
        .IDEX_memRead   (IDEX_memRead),
        .IDEX_regWrite  (IDEX_regWrite),
        .IDEX_desReg    (IDEX_desReg),
        .EXMEM_memRead  (EXMEM_memRead),
        .EXMEM_memWrite (EXMEM_memWrite),
        .EXMEM_desReg   (EXMEM_desReg),
        .dmem_ready     (dmem_ready),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEX_bubble    (IDEX_bubble),
        .IFID_flush     (IFID_flush),
        .pipeFreeze     (pipeFreeze),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .memwait_cycles (memwait_cycles),
        .mem_timeout    (mem_timeout)
    );

    always #5 clk = ~clk;

    // ctl = {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipeFreeze}
    typedef struct {
        logic [4:0] ctl;
        int         st;
        int         fl;
        int         mw;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic m_wait;
    int   m_wcnt, m_st, m_fl, m_mw;
    logic m_to;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [4:0] d);
        return (d != 5'd0) && ((d == IFID_rs) || (IFID_usesRt && (d == IFID_rt)));
    endfunction

    task automatic clr();
        IFID_rs = 0; IFID_rt = 0; IFID_usesRt = 0; ID_branch = 0; ID_branchTaken = 0;
        IDEX_memRead = 0; IDEX_regWrite = 0; IDEX_desReg = 0;
        EXMEM_memRead = 0; EXMEM_memWrite = 0; EXMEM_desReg = 0; dmem_ready = 1;
    endtask

    // One clock: predict, push, compare at negedge, advance model at posedge.
    task automatic cycle();
        exp_t e, got;
        logic lu, bh, busy, frz, stl, fls;
        logic n_wait, n_to;
        int   n_wcnt, n_st, n_fl, n_mw;
        lu   = IDEX_memRead && m_hit(IDEX_desReg);
        bh   = ID_branch && ((IDEX_regWrite && m_hit(IDEX_desReg)) ||
                             (EXMEM_memRead && m_hit(EXMEM_desReg)));
        busy = (EXMEM_memRead || EXMEM_memWrite) && !dmem_ready;
        frz  = !reset && (m_wait ? !dmem_ready : busy);
        stl  = !reset && !frz && (lu || bh);
        fls  = !reset && !frz && !(lu || bh) && ID_branch && ID_branchTaken;
        if (frz)      e.ctl = 5'b00001;
        else if (stl) e.ctl = 5'b00100;
        else if (fls) e.ctl = 5'b11010;
        else          e.ctl = 5'b11000;
        e.st = m_st; e.fl = m_fl; e.mw = m_mw; e.to = m_to;
        sb.push_back(e);
        if (reset) begin
            n_wait = 0; n_wcnt = 0; n_to = 0; n_st = 0; n_fl = 0; n_mw = 0;
        end else begin
            n_wait = frz;
            n_wcnt = frz ? ((m_wcnt + 1 > TIMEOUT) ? TIMEOUT : m_wcnt + 1) : 0;
            n_to   = m_to || (frz && (m_wcnt + 1 >= TIMEOUT));
            n_st   = (stl && m_st < CMAX) ? m_st + 1 : m_st;
            n_fl   = (fls && m_fl < CMAX) ? m_fl + 1 : m_fl;
            n_mw   = (frz && m_mw < CMAX) ? m_mw + 1 : m_mw;
        end
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("ctl", 32'({PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipeFreeze}), 32'(got.ctl));
            check("stall_cycles", 32'(stall_cycles), 32'(got.st));
            check("flush_count", 32'(flush_count), 32'(got.fl));
            check("memwait_cycles", 32'(memwait_cycles), 32'(got.mw));
            check("mem_timeout", 32'(mem_timeout), 32'(got.to));
        end
        @(posedge clk);
        m_wait = n_wait; m_wcnt = n_wcnt; m_to = n_to;
        m_st = n_st; m_fl = n_fl; m_mw = n_mw;
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        m_wait = 0; m_wcnt = 0; m_to = 0; m_st = 0; m_fl = 0; m_mw = 0;
        @(posedge clk); #1;

        // Reset held with a load-use present: outputs forced to run values
        IDEX_memRead = 1; IDEX_desReg = 5'd2; IFID_rs = 5'd2;
        cycle(); cycle();
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        reset = 1'b0;

        // lw $2 in EX, add $3,$2,$4 in ID: one bubble
        clr(); IDEX_memRead = 1; IDEX_regWrite = 1; IDEX_desReg = 5'd2;
        IFID_rs = 5'd2; IFID_rt = 5'd4; IFID_usesRt = 1;
        cycle();
        clr(); EXMEM_memRead = 1; EXMEM_desReg = 5'd2; cycle();
        check("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // lw $5 then beq $5,$6 taken: two stalls then one flush
        clr(); ID_branch = 1; ID_branchTaken = 1; IFID_rs = 5'd5; IFID_rt = 5'd6; IFID_usesRt = 1;
        IDEX_memRead = 1; IDEX_regWrite = 1; IDEX_desReg = 5'd5;
        cycle();
        IDEX_memRead = 0; IDEX_regWrite = 0; IDEX_desReg = 0;
        EXMEM_memRead = 1; EXMEM_desReg = 5'd5;
        cycle();
        EXMEM_memRead = 0; EXMEM_desReg = 0;
        cycle();
        check("br_stall_cycles", 32'(stall_cycles), 32'd3);
        check("br_flush_count", 32'(flush_count), 32'd1);

        // $zero never hazards; add $7 feeding beq $7 stalls once
        clr(); IDEX_memRead = 1; IDEX_regWrite = 1; IDEX_desReg = 5'd0; IFID_rs = 5'd0;
        cycle();
        check("zero_no_stall", 32'(stall_cycles), 32'd3);
        clr(); IDEX_regWrite = 1; IDEX_desReg = 5'd7; ID_branch = 1; IFID_rs = 5'd7;
        cycle();
        IDEX_regWrite = 0; IDEX_desReg = 0;
        cycle();
        check("alu_br_stall", 32'(stall_cycles), 32'd4);

        // sw in MEM not ready 3 cycles with load-use pending: freeze wins
        clr(); EXMEM_memWrite = 1; dmem_ready = 0;
        IDEX_memRead = 1; IDEX_desReg = 5'd3; IFID_rs = 5'd3;
        repeat (3) cycle();
        dmem_ready = 1;
        cycle();
        check("sw_memwait", 32'(memwait_cycles), 32'd3);
        check("sw_bubble_stall", 32'(stall_cycles), 32'd5);
        check("sw_no_timeout", 32'(mem_timeout), 32'd0);

        // Long wait: timeout after 4th freeze cycle, memwait saturates
        clr(); EXMEM_memRead = 1; EXMEM_desReg = 5'd9; dmem_ready = 0;
        repeat (3) cycle();
        check("to_before", 32'(mem_timeout), 32'd0);
        cycle();
        check("to_after4", 32'(mem_timeout), 32'd1);
        repeat (16) cycle();
        check("memwait_sat", 32'(memwait_cycles), 32'(CMAX));
        dmem_ready = 1;
        cycle(); cycle();
        check("to_sticky", 32'(mem_timeout), 32'd1);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("to_cleared", 32'(mem_timeout), 32'd0);
        check("mw_cleared", 32'(memwait_cycles), 32'd0);

        // Reset mid-MEM_WAIT with hazards active
        clr(); EXMEM_memWrite = 1; dmem_ready = 0;
        IDEX_memRead = 1; IDEX_desReg = 5'd4; IFID_rs = 5'd4;
        cycle(); cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        dmem_ready = 1; cycle();
        dmem_ready = 0; cycle(); cycle();
        dmem_ready = 1; cycle();

        // Random mix
        for (int i = 0; i < 200; i++) begin
            IFID_rs        = 5'($urandom_range(0, 3));
            IFID_rt        = 5'($urandom_range(0, 3));
            IFID_usesRt    = 1'($urandom);
            ID_branch      = 1'($urandom);
            ID_branchTaken = 1'($urandom);
            IDEX_memRead   = 1'($urandom);
            IDEX_regWrite  = 1'($urandom);
            IDEX_desReg    = 5'($urandom_range(0, 3));
            EXMEM_memRead  = 1'($urandom);
            EXMEM_memWrite = ($urandom_range(0, 3) == 0);
            EXMEM_desReg   = 5'($urandom_range(0, 3));
            dmem_ready     = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 39) == 0);
            cycle();
        end
        reset = 1'b0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
